// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the front-end stages: default widths, reset
// constants, the IF/ID bundle layout and the per-edge fetch mode.
`timescale 1ns/1ps
package fetch_stage_pkg;

    localparam int          PC_WIDTH  = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          CNT_WIDTH = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instr;
        logic                valid;
    } if_id_t;

    // Priority of the per-edge action: flush beats stall beats run.
    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2
    } fetch_mode_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with freeze and flush. The flush value and the
// reset value are the same bubble, so a flushed stage looks freshly reset.
`timescale 1ns/1ps
module if_id_reg #(
    parameter int           W         = 65,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= CLEAR_VAL;
        end else if (flush) begin
            q <= CLEAR_VAL;
        end else if (!freeze) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, combinational instruction-memory
// address, IF/ID register for decode, and a count of valid fetches.
`timescale 1ns/1ps
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH  = fetch_stage_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = fetch_stage_pkg::RESET_PC[PC_WIDTH-1:0],
    parameter logic [31:0]         NOP_INSTR = fetch_stage_pkg::NOP_INSTR,
    parameter int                  CNT_WIDTH = fetch_stage_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_addr,
    output logic [PC_WIDTH-1:0]  inst_addr,
    input  logic [31:0]          inst_data,
    output logic [PC_WIDTH-1:0]  PC_out,
    output logic [31:0]          Instruction,
    output logic                 valid_out,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam int             IF_W     = PC_WIDTH + 33;
    localparam logic [IF_W-1:0] IF_CLEAR = {{PC_WIDTH{1'b0}}, NOP_INSTR, 1'b0};

    logic [PC_WIDTH-1:0]  pc_reg;
    logic [PC_WIDTH-1:0]  pc_next;
    logic [PC_WIDTH-1:0]  branch_target;
    logic [CNT_WIDTH-1:0] fetch_count_reg;
    fetch_mode_e          mode;
    logic [IF_W-1:0]      if_id_d;
    logic [IF_W-1:0]      if_id_q;

    assign pc_next       = pc_reg + PC_WIDTH'(4);
    assign branch_target = branch_addr & ~PC_WIDTH'(3);

    always_comb begin
        mode = MODE_RUN;
        if (branch_taken) begin
            mode = MODE_FLUSH;
        end else if (freeze) begin
            mode = MODE_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            fetch_count_reg <= '0;
        end else begin
            case (mode)
                MODE_FLUSH: pc_reg <= branch_target;
                MODE_RUN: begin
                    pc_reg          <= pc_next;
                    fetch_count_reg <= fetch_count_reg + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // PC_out carries the sequential successor of the fetched instruction.
    assign if_id_d = {pc_next, inst_data, 1'b1};

    if_id_reg #(
        .W         (IF_W),
        .CLEAR_VAL (IF_CLEAR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .freeze (mode == MODE_STALL),
        .flush  (mode == MODE_FLUSH),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign inst_addr                         = pc_reg;
    assign {PC_out, Instruction, valid_out}  = if_id_q;
    assign fetch_count                       = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async-reset
// sequence, then random freeze/branch traffic against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        valid_out;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the fetch stage should be showing right now.
    logic [31:0] m_pc, m_pc_out, m_instr, m_count;
    logic        m_valid;

    typedef struct {
        logic        f;
        logic        b;
        logic [31:0] addr;
        logic [31:0] e_inst_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc_out;
        logic        e_valid;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000;
    endfunction

    assign inst_data = mem_word(inst_addr);

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .inst_addr    (inst_addr),
        .inst_data    (inst_data),
        .PC_out       (PC_out),
        .Instruction  (Instruction),
        .valid_out    (valid_out),
        .fetch_count  (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_ia, input logic [31:0] e_in,
                             input logic [31:0] e_po, input logic e_v, input logic [31:0] e_c);
        check({tag, " inst_addr"},   inst_addr,   e_ia);
        check({tag, " Instruction"}, Instruction, e_in);
        check({tag, " PC_out"},      PC_out,      e_po);
        check({tag, " valid_out"},   {31'd0, valid_out}, {31'd0, e_v});
        check({tag, " fetch_count"}, fetch_count, e_c);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pc_out = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    endtask

    // Apply one rising edge to the model from the rules: redirect, else hold, else advance.
    task automatic model_edge(input logic f, input logic b, input logic [31:0] a);
        if (b) begin
            m_pc = {a[31:2], 2'b00};
            m_instr = 32'h0; m_pc_out = 32'h0; m_valid = 1'b0;
        end else if (!f) begin
            m_instr  = mem_word(m_pc);
            m_pc_out = m_pc + 32'd4;
            m_valid  = 1'b1;
            m_count  = m_count + 32'd1;
            m_pc     = m_pc + 32'd4;
        end
    endtask

    task automatic drive_edge(input logic f, input logic b, input logic [31:0] a);
        freeze = f; branch_taken = b; branch_addr = a;
        @(posedge clk);
        model_edge(f, b, a);
        #1;
    endtask

    task automatic add_vec(input logic f, input logic b, input logic [31:0] a, input logic [31:0] ia,
                           input logic [31:0] in, input logic [31:0] po, input logic v, input logic [31:0] c);
        vec_t t;
        t.f = f; t.b = b; t.addr = a; t.e_inst_addr = ia; t.e_instr = in;
        t.e_pc_out = po; t.e_valid = v; t.e_count = c;
        vecs.push_back(t);
    endtask

    initial begin
        // f  b  branch_addr    inst_addr      Instruction    PC_out         v  count
        add_vec(0, 0, 32'h0,        32'h4,         32'h1000,      32'h4,         1, 1);
        add_vec(0, 0, 32'h0,        32'h8,         32'h1004,      32'h8,         1, 2);
        add_vec(1, 0, 32'h0,        32'h8,         32'h1004,      32'h8,         1, 2);
        add_vec(1, 0, 32'h0,        32'h8,         32'h1004,      32'h8,         1, 2);
        add_vec(1, 0, 32'h0,        32'h8,         32'h1004,      32'h8,         1, 2);
        add_vec(0, 0, 32'h0,        32'hC,         32'h1008,      32'hC,         1, 3);
        add_vec(0, 1, 32'h40,       32'h40,        32'h0,         32'h0,         0, 3);
        add_vec(0, 0, 32'h0,        32'h44,        32'h1040,      32'h44,        1, 4);
        add_vec(1, 1, 32'h83,       32'h80,        32'h0,         32'h0,         0, 4);
        add_vec(0, 1, 32'h201,      32'h200,       32'h0,         32'h0,         0, 4);
        add_vec(0, 0, 32'h0,        32'h204,       32'h1200,      32'h204,       1, 5);
        add_vec(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,        32'h0,         0, 5);
        add_vec(0, 0, 32'h0,        32'h0,         32'h0000_0FFC, 32'h0,         1, 6);
        add_vec(0, 0, 32'h0,        32'h4,         32'h1000,      32'h4,         1, 7);

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_edge(vecs[i].f, vecs[i].b, vecs[i].addr);
            $display("[TB] vec %0d f=%0b b=%0b addr=%h -> inst_addr=%h instr=%h pc_out=%h v=%0b cnt=%0d",
                     i, vecs[i].f, vecs[i].b, vecs[i].addr, inst_addr, Instruction, PC_out, valid_out, fetch_count);
            check_all($sformatf("vec%0d", i), vecs[i].e_inst_addr, vecs[i].e_instr,
                      vecs[i].e_pc_out, vecs[i].e_valid, vecs[i].e_count);
        end

        // Asynchronous reset landing mid-freeze, between clock edges.
        drive_edge(1, 0, 32'h0);
        drive_edge(1, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        $display("[TB] async reset mid-freeze -> inst_addr=%h instr=%h v=%0b cnt=%0d",
                 inst_addr, Instruction, valid_out, fetch_count);
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_edge(0, 0, 32'h0);
        $display("[TB] restart -> inst_addr=%h instr=%h pc_out=%h cnt=%0d", inst_addr, Instruction, PC_out, fetch_count);
        check_all("restart", 32'h4, 32'h1000, 32'h4, 1'b1, 32'h1);

        // Random traffic against the behavioural model.
        for (int i = 0; i < 400; i++) begin
            logic f, b;
            logic [31:0] a;
            f = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 15);
            a = (i % 50 == 7) ? 32'hFFFF_FFFC : $urandom();
            drive_edge(f, b, a);
            $display("[TB] rnd %0d f=%0b b=%0b addr=%h -> inst_addr=%h instr=%h pc_out=%h v=%0b cnt=%0d",
                     i, f, b, a, inst_addr, Instruction, PC_out, valid_out, fetch_count);
            check_all($sformatf("rnd%0d", i), m_pc, m_instr, m_pc_out, m_valid, m_count);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. Holds the program counter and drives a combinational instruction-memory read. Latches {PC+4, instruction, valid} into the IF/ID register for decode. Supports hazard freeze, branch redirect and flush, and keeps a retired-fetch counter for bring-up.

Parameters:
PC_WIDTH, 32, width of PC, memory address and PC_out
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush/reset
CNT_WIDTH, 32, width of fetch counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
freeze  input  1  hazard stall from hazard unit; holds PC and IF/ID
branch_taken  input  1  redirect request from execute stage; also flushes IF/ID
branch_addr  input  PC_WIDTH  redirect target; bits[1:0] ignored (forced 0)
inst_addr  output  PC_WIDTH  byte address to instruction memory (= pc_reg, combinational)
inst_data  input  32  instruction word returned combinationally for inst_addr
PC_out  output  PC_WIDTH  registered PC+4 of the instruction in IF/ID (feeds decode PC_in)
Instruction  output  32  registered instruction in IF/ID (feeds decode Instruction)
valid_out  output  1  IF/ID holds a real instruction (0 = bubble)
fetch_count  output  CNT_WIDTH  number of instructions that entered IF/ID with valid=1

Behaviour:
- Reset (async, any time, including mid-stall): pc_reg=RESET_PC, PC_out=0, Instruction=NOP_INSTR, valid_out=0, fetch_count=0. First fetch uses RESET_PC in the first cycle after rst deasserts.
- pc_next = pc_reg + 4, computed modulo 2^PC_WIDTH. Wrap from 32'hFFFF_FFFC to 0 is silent.
- PC update priority per rising edge: branch_taken, then freeze, then sequential.
  - branch_taken=1: pc_reg <= {branch_addr[PC_WIDTH-1:2],2'b00}, whether or not freeze is set.
  - else freeze=1: pc_reg holds.
  - else: pc_reg <= pc_next.
- IF/ID update per rising edge, same priority:
  - branch_taken=1 (flush): Instruction<=NOP_INSTR, PC_out<=0, valid_out<=0. The wrong-path fetch is discarded.
  - else freeze=1: all IF/ID outputs hold. fetch_count holds.
  - else: Instruction<=inst_data, PC_out<=pc_next, valid_out<=1, fetch_count<=fetch_count+1 (wraps silently).
- Latency: instruction at address A appears on Instruction one edge after inst_addr=A, with PC_out=A+4.
- Branch penalty is one bubble in IF/ID from this block. The first target instruction reaches IF/ID on the second edge after branch_taken.
- Back-to-back branch_taken on consecutive cycles: each redirect is honoured. The latest target wins, and IF/ID stays flushed.
- freeze held for N cycles: PC and IF/ID stay frozen N cycles and no instruction is lost or duplicated.
- No internal FSM beyond the implicit RUN/STALL/FLUSH selection above. All outputs are registered except inst_addr.

Decomposition:
- Shared pipeline package: PC_WIDTH, NOP_INSTR, RESET_PC constants; IF/ID bundle typedef {pc, instr, valid}, reused by the decode and ID/EX register work.
- One natural sub-module: if_id_reg. It is a generic pipeline register with freeze/flush/valid and is reusable for ID/EX. pc_reg and the counter stay in fetch_stage.

Test Plan:
- Reset then run, freeze=0, branch=0, memory word(A)=A+32'h1000 -> Instruction sequence 0x1000,0x1004,0x1008; PC_out 4,8,12; valid_out=1; fetch_count=3 after 3 edges.
- Freeze at pc=8 for 3 cycles -> inst_addr stays 8, Instruction/PC_out/fetch_count unchanged for 3 edges, then resume with word(8), PC_out=12.
- branch_taken=1 with branch_addr=32'h40 at pc=12 -> next edge valid_out=0, Instruction=NOP_INSTR, inst_addr=0x40. Following edge Instruction=word(0x40), PC_out=0x44.
- branch_taken and freeze both 1, branch_addr=32'h83 -> branch wins: inst_addr=0x80, IF/ID flushed, fetch_count unchanged.
- Wrap: force pc=32'hFFFF_FFFC via branch -> following fetch PC_out=0, next inst_addr=0.
- Assert rst asynchronously mid-freeze between clock edges -> outputs reach reset values immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
